// File: rtl/pe_pkg.sv
// Width helpers and saturation bounds shared by the processing element, array top and drain FIFO.
package pe_pkg;

    function automatic int unsigned acc_bits(int unsigned i_bits, int unsigned max_len);
        return 2 * i_bits + $clog2(max_len);
    endfunction

    function automatic int unsigned len_bits(int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic longint sat_max(int unsigned bits);
        return (longint'(1) <<< (bits - 1)) - 1;
    endfunction

    function automatic longint sat_min(int unsigned bits);
        return -(longint'(1) <<< (bits - 1));
    endfunction

endpackage

// File: rtl/pe_round_sat.sv
// Result formatter: arithmetic right shift, then either wrap to OUT_BITS or
// round-half-up and clamp to the signed OUT_BITS range.
module pe_round_sat
    import pe_pkg::*;
#(
    parameter int unsigned IN_BITS  = 22,
    parameter int unsigned OUT_BITS = 22,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned SAT_EN   = 0
) (
    input  logic [IN_BITS-1:0]  value_i,
    output logic [OUT_BITS-1:0] value_o
);

    // One guard bit for the rounding add, one so the clamp bounds always fit.
    localparam int unsigned WW = ((IN_BITS + 1 > OUT_BITS) ? IN_BITS + 1 : OUT_BITS) + 1;
    localparam logic signed [WW-1:0] RoundC =
        (SHIFT > 0) ? (WW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [WW-1:0] MaxC = WW'(sat_max(OUT_BITS));
    localparam logic signed [WW-1:0] MinC = WW'(sat_min(OUT_BITS));

    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] trn_shift;
    logic signed [WW-1:0] rnd_shift;

    always_comb begin
        ext       = WW'($signed(value_i));
        trn_shift = ext >>> SHIFT;
        rnd_shift = (ext + RoundC) >>> SHIFT;
        if (SAT_EN != 0) begin
            if (rnd_shift > MaxC) begin
                value_o = OUT_BITS'(MaxC);
            end else if (rnd_shift < MinC) begin
                value_o = OUT_BITS'(MinC);
            end else begin
                value_o = OUT_BITS'(rnd_shift);
            end
        end else begin
            value_o = OUT_BITS'(trn_shift);
        end
    end

endmodule

// File: rtl/pe_mac_stream.sv
// Systolic grid node: signed MAC over a run-time length, operand forwarding, and a
// one-entry valid/ready result register so consecutive dot products run without bubbles.
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int unsigned I_BITS   = 8,
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned ACC_BITS = acc_bits(I_BITS, MAX_LEN),
    parameter int unsigned O_BITS   = ACC_BITS,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned SAT_EN   = 0,
    parameter int unsigned LEN_BITS = len_bits(MAX_LEN)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [I_BITS-1:0]   i_a,
    input  logic [I_BITS-1:0]   i_b,
    input  logic [LEN_BITS-1:0] i_len,
    output logic                o_stall,
    output logic [I_BITS-1:0]   o_a,
    output logic [I_BITS-1:0]   o_b,
    output logic                o_valid,
    output logic [O_BITS-1:0]   o_c,
    output logic                o_c_valid,
    input  logic                i_c_ready
);

    logic signed [2*I_BITS-1:0] prod;
    logic signed [ACC_BITS-1:0] prod_ext;
    logic signed [ACC_BITS-1:0] sum;
    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic [LEN_BITS-1:0]        cnt_q, cnt_d;
    logic [LEN_BITS-1:0]        len_q, len_d;
    logic [LEN_BITS-1:0]        len_in;
    logic [LEN_BITS-1:0]        cur_len;
    logic                       final_beat;
    logic                       accept;
    logic [I_BITS-1:0]          a_q, b_q;
    logic                       valid_q;
    logic [O_BITS-1:0]          c_q, c_d, c_fmt;
    logic                       c_valid_q, c_valid_d;

    pe_round_sat #(
        .IN_BITS  (ACC_BITS),
        .OUT_BITS (O_BITS),
        .SHIFT    (SHIFT),
        .SAT_EN   (SAT_EN)
    ) u_round_sat (
        .value_i (sum),
        .value_o (c_fmt)
    );

    always_comb begin
        prod     = (2*I_BITS)'($signed(i_a)) * (2*I_BITS)'($signed(i_b));
        prod_ext = ACC_BITS'(prod);
        if (i_len == '0) begin
            len_in = LEN_BITS'(1);
        end else if (i_len > LEN_BITS'(MAX_LEN)) begin
            len_in = LEN_BITS'(MAX_LEN);
        end else begin
            len_in = i_len;
        end
        // The first beat of a run uses the incoming length before it is latched.
        cur_len    = (cnt_q == '0) ? len_in : len_q;
        final_beat = (cnt_q == cur_len - LEN_BITS'(1));
        sum        = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
        o_stall    = i_valid & final_beat & c_valid_q & ~i_c_ready;
        accept     = i_valid & ~o_stall;

        cnt_d     = cnt_q;
        len_d     = len_q;
        acc_d     = acc_q;
        c_d       = c_q;
        c_valid_d = c_valid_q & ~i_c_ready;
        if (accept) begin
            if (cnt_q == '0) begin
                len_d = len_in;
            end
            if (final_beat) begin
                cnt_d     = '0;
                c_d       = c_fmt;
                c_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + LEN_BITS'(1);
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= LEN_BITS'(1);
            a_q       <= '0;
            b_q       <= '0;
            valid_q   <= 1'b0;
            c_q       <= '0;
            c_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            valid_q   <= accept;
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
            if (accept) begin
                a_q <= i_a;
                b_q <= i_b;
            end
        end
    end

    assign o_a       = a_q;
    assign o_b       = b_q;
    assign o_valid   = valid_q;
    assign o_c       = c_q;
    assign o_c_valid = c_valid_q;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench driving a full-resolution PE and a rounding/saturating PE with
// the same beats; expected results are queued per instance and checked on drain.
module tb_pe_mac_stream;

    logic              clk;
    logic              rst;
    logic              valid;
    logic signed [7:0] a_s, b_s;
    logic [6:0]        len_s;
    logic              c_ready;

    logic        stall0, ov0, cv0;
    logic [7:0]  oa0, ob0;
    logic [21:0] c0;
    logic        stall1, ov1, cv1;
    logic [7:0]  oa1, ob1;
    logic [7:0]  c1;

    int checks = 0;
    int errors = 0;
    longint q0[$];
    longint q1[$];

    pe_mac_stream u_dut0 (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_valid   (valid),
        .i_a       (a_s),
        .i_b       (b_s),
        .i_len     (len_s),
        .o_stall   (stall0),
        .o_a       (oa0),
        .o_b       (ob0),
        .o_valid   (ov0),
        .o_c       (c0),
        .o_c_valid (cv0),
        .i_c_ready (c_ready)
    );

    pe_mac_stream #(
        .I_BITS  (8),
        .MAX_LEN (64),
        .O_BITS  (8),
        .SHIFT   (7),
        .SAT_EN  (1)
    ) u_dut1 (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_valid   (valid),
        .i_a       (a_s),
        .i_b       (b_s),
        .i_len     (len_s),
        .o_stall   (stall1),
        .o_a       (oa1),
        .o_b       (ob1),
        .o_valid   (ov1),
        .o_c       (c1),
        .o_c_valid (cv1),
        .i_c_ready (c_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sat_ref(longint x);
        longint r;
        r = (x + 64) >>> 7;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input longint s);
        q0.push_back(s);
        q1.push_back(sat_ref(s));
    endtask

    task automatic drain_chk(input string tag, input logic cv, input longint c, input logic rdy,
                             inout longint q[$]);
        if (cv) begin
            if (q.size() == 0) begin
                chk({tag, "_extra"}, cv, 0);
            end else begin
                chk(tag, c, q[0]);
                if (rdy) void'(q.pop_front());
            end
        end
    endtask

    // Drive one cycle; check stall/result before the edge, forwarding after it.
    task automatic step(input logic v, input int a, input int b, input int len, input logic rdy,
                        input logic exp_stall, input int exp_cv);
        logic acc;
        valid   = v;
        a_s     = 8'(a);
        b_s     = 8'(b);
        len_s   = 7'(len);
        c_ready = rdy;
        @(negedge clk);
        chk("stall0", stall0, exp_stall);
        chk("stall1", stall1, exp_stall);
        if (exp_cv >= 0) begin
            chk("cvalid0", cv0, exp_cv);
            chk("cvalid1", cv1, exp_cv);
        end
        drain_chk("c0", cv0, $signed(c0), rdy, q0);
        drain_chk("c1", cv1, $signed(c1), rdy, q1);
        acc = v & ~exp_stall;
        @(posedge clk);
        #1;
        chk("ovalid0", ov0, acc);
        chk("ovalid1", ov1, acc);
        if (acc) begin
            chk("oa0", $signed(oa0), a);
            chk("ob0", $signed(ob0), b);
            chk("oa1", $signed(oa1), a);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        chk("rst_c0", c0, 0);
        chk("rst_cv0", cv0, 0);
        chk("rst_ov0", ov0, 0);
        chk("rst_oa0", oa0, 0);
        chk("rst_ob0", ob0, 0);
        chk("rst_c1", c1, 0);
        chk("rst_cv1", cv1, 0);
        chk("rst_ov1", ov1, 0);
    endtask

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        a_s     = '0;
        b_s     = '0;
        len_s   = '0;
        c_ready = 1'b1;
        do_reset();
        step(0, 0, 0, 1, 1, 0, 0);

        // len=4, 64*64 four times
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(16384);
            step(1, 64, 64, 4, 1, 0, -1);
        end

        // len=1 stream, result every cycle
        push(21);  step(1, 3, 7, 1, 1, 0, 1);
        push(-14); step(1, -2, 7, 1, 1, 0, 1);
        push(35);  step(1, 5, 7, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);

        // Back-pressure: 32 held while the next final beat stalls
        step(1, 4, 4, 2, 1, 0, 0);
        push(32);  step(1, 4, 4, 2, 1, 0, 0);
        step(1, 2, 3, 2, 0, 0, 1);
        push(12);  step(1, 2, 3, 2, 0, 1, 1);
        step(1, 2, 3, 2, 0, 1, 1);
        step(1, 2, 3, 2, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);

        // Saturation cases on the formatted instance
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(65536);
            step(1, -128, -128, 4, 1, 0, -1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(-65024);
            step(1, -128, 127, 4, 1, 0, -1);
        end
        push(127); step(1, 1, 127, 1, 1, 0, -1);
        step(0, 0, 0, 1, 1, 0, 1);

        // i_len=0 acts as 1; mid-run length changes are ignored
        push(10);  step(1, 2, 5, 0, 1, 0, 0);
        step(1, 1, 1, 3, 1, 0, 1);
        step(1, 1, 1, 1, 1, 0, 0);
        push(3);   step(1, 1, 1, 1, 1, 0, 0);
        push(16);  step(1, 4, 4, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);

        // Reset with a pending result and a partial sum
        push(25);  step(1, 5, 5, 1, 0, 0, 0);
        step(1, 1, 1, 4, 0, 0, 1);
        step(1, 1, 1, 4, 0, 0, 1);
        do_reset();
        step(1, 1, 1, 2, 1, 0, 0);
        push(2);   step(1, 1, 1, 2, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_mac_stream.md
# pe_mac_stream

Streaming, handshaked successor to the counter-based systolic processing element. Each instance multiplies signed operands, accumulates over a run-time accumulation length, and forwards operands to its neighbours one cycle later. It hands each finished dot product to a one-entry result holding register with valid/ready drain, so back-to-back matrices run without bubbles. It sits at every grid node of the systolic array; result ports feed the column drain / FIFO logic.

## Interface
- I_BITS, 8, signed operand width (Q1.(I_BITS-1))
- MAX_LEN, 64, maximum accumulation length (beats per result)
- ACC_BITS, 2*I_BITS+$clog2(MAX_LEN), internal accumulator width, full resolution
- O_BITS, ACC_BITS, result width
- SHIFT, 0, right shift (fraction bits dropped) applied to the result
- SAT_EN, 0, 1 = round-half-up plus saturate to O_BITS; 0 = truncate (wrap)
- LEN_BITS, $clog2(MAX_LEN+1), width of i_len
- i_clock in 1 clock, all logic on rising edge
- i_reset in 1 synchronous, active-high reset
- i_valid in 1 operand beat valid
- i_a in I_BITS signed operand A
- i_b in I_BITS signed operand B
- i_len in LEN_BITS accumulation length for the next result
- o_stall out 1 beat not accepted this cycle; upstream holds its data
- o_a out I_BITS registered i_a, to the east neighbour
- o_b out I_BITS registered i_b, to the south neighbour
- o_valid out 1 registered accepted-beat flag, to neighbours
- o_c out O_BITS result, signed
- o_c_valid out 1 result holding register full
- i_c_ready in 1 drain accepts the result

## Operation
- accept = i_valid & ~o_stall. Only accepted beats update the accumulator or the counter.
- prod = i_a*i_b, full 2*I_BITS signed, sign-extended to ACC_BITS.
- cnt counts accepted beats, 0..len-1. len is latched from i_len on the accepted beat with cnt==0. A latched value of 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN.
- Non-final beat: acc <= (cnt==0 ? prod : acc+prod), cnt++.
- Final beat (cnt==len-1): result = acc+prod (prod alone if len==1) loads the holding register, o_c_valid <= 1, cnt <= 0. The next beat starts a fresh sum; there is no overwrite hazard on acc.
- o_stall = i_valid & final-beat & o_c_valid & ~i_c_ready, combinational. The final beat may load when the holding register is draining in the same cycle.
- Holding register clears o_c_valid on i_c_ready & o_c_valid, unless a new result loads in the same cycle. In that case o_c_valid stays 1 with the new value.
- o_c and o_c_valid are stable while o_c_valid & ~i_c_ready.
- Result formatting:
  - SAT_EN=0: o_c = (result >>> SHIFT)[O_BITS-1:0].
  - SAT_EN=1: add 2^(SHIFT-1) when SHIFT>0, arithmetic shift, clamp to [-2^(O_BITS-1), 2^(O_BITS-1)-1].
- Overflow of ACC_BITS cannot occur for len ≤ MAX_LEN, so no accumulator overflow logic is needed.

## Timing
- Reset: o_a=0, o_b=0, o_valid=0, o_c=0, o_c_valid=0, acc=0, cnt=0, len=1. o_stall=0 because o_c_valid=0.
- Forwarding latency: o_a/o_b/o_valid are 1 cycle after an accepted beat.
- On a stalled cycle: o_valid <= 0; o_a/o_b hold their previous values.
- Result latency: o_c_valid rises on the edge that accepts the final beat, so it is visible the cycle after.
- Sustained throughput: 1 beat/cycle with i_c_ready tied high, including len=1 (a new result every cycle).
- Reset asserted mid-accumulation or with a pending result discards both; the next accepted beat starts at cnt=0.
- i_len is ignored except on cnt==0 accepted beats.

## Structure
- Shared package pe_pkg: clog2-derived width helpers (ACC_BITS, LEN_BITS) and signed min/max constant functions for the saturation bounds. Array top and FIFO logic reuse these.
- One combinational sub-module, pe_round_sat (parameters IN_BITS, OUT_BITS, SHIFT, SAT_EN), does result formatting. It is reused by the drain path.
- Remaining logic is flat: counter, accumulator, holding register, forwarding registers.

## Test plan
- I_BITS=8, len=4, a=b=64 for 4 beats, i_c_ready=1 -> o_c=16384 one cycle after beat 4; o_a/o_b=64 each cycle after a beat.
- len=1 stream a=3,-2,5 with b=7 -> o_c=21,-14,35 on consecutive cycles; o_c_valid high continuously.
- len=2, i_c_ready=0 after the first result (4·4+4·4=32) -> o_stall on the second result's final beat; o_c holds 32. Raise i_c_ready -> 32 drains, then the new result loads, with no beat lost.
- SAT_EN=1, O_BITS=8, SHIFT=7, len=4, a=b=-128 -> result clamps to 127; a=b=64 -> (16384+64)>>>7 = 128 clamps to 127; a=1, b=127, len=1 -> (127+64)>>>7 = 1.
- i_len=0 -> behaves as len=1; i_len changed mid-run -> change takes effect only at the next result boundary.
- i_reset for 1 cycle at cnt=2 with o_c_valid=1 -> all outputs 0 next cycle; a following len=2 run of 1·1+1·1 gives 2.
